// File: rtl/note_spi_rx.sv
// ---------------------------------------------------------------------------
// note_spi_rx
//
// SPI receiver that takes three note periods from the PIC and gives them to
// the voice generators. A frame is 3*WORD_W bits, sent MSB first while load
// is high. When load falls, the frame is committed only if exactly 3*WORD_W
// sck rising edges were seen. The three periods then update together, so a
// voice never sees a mix of old and new notes. A frame of any other length
// is dropped and reported with a single-cycle frame_err pulse.
//
// Parameters
//   SYNC_STAGES  depth of the synchroniser for sck/sdi/load (2 or 3)
//   WORD_W       bits per voice period
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   sck          SPI clock from the PIC (asynchronous, idles low)
//   sdi          SPI data, MSB first, changes on sck falling edge
//   load         frame enable, high for the whole frame (asynchronous)
//   prd1..prd3   committed periods in clk cycles, top bit always 0
//   voice_on     bit i-1 high when prd_i is non-zero
//   frame_done   one-cycle pulse when a frame is committed
//   frame_err    one-cycle pulse when a frame is discarded
// ---------------------------------------------------------------------------
module note_spi_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int WORD_W      = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sck,
   input  logic              sdi,
   input  logic              load,
   output logic [WORD_W:0]   prd1,
   output logic [WORD_W:0]   prd2,
   output logic [WORD_W:0]   prd3,
   output logic [2:0]        voice_on,
   output logic              frame_done,
   output logic              frame_err
);

   localparam int         FRAME_W    = 3 * WORD_W;
   localparam logic [6:0] FRAME_BITS = 7'(FRAME_W);
   localparam logic [6:0] COUNT_MAX  = 7'd127;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SHIFT  = 2'd1;
   localparam logic [1:0] COMMIT = 2'd2;

   logic [SYNC_STAGES-1:0] sckSync_q;
   logic [SYNC_STAGES-1:0] sdiSync_q;
   logic [SYNC_STAGES-1:0] loadSync_q;
   logic                   sckDly_q;
   logic                   loadDly_q;

   logic                   sckSync;
   logic                   sdiSync;
   logic                   loadSync;
   logic                   sckRise;
   logic                   loadRise;
   logic                   loadFall;

   logic [1:0]             state_q,     state_d;
   logic [FRAME_W-1:0]     shift_q,     shift_d;
   logic [6:0]             count_q,     count_d;
   logic [WORD_W-1:0]      prd1_q,      prd1_d;
   logic [WORD_W-1:0]      prd2_q,      prd2_d;
   logic [WORD_W-1:0]      prd3_q,      prd3_d;
   logic [2:0]             voice_q,     voice_d;
   logic                   frameDone_q, frameDone_d;
   logic                   frameErr_q,  frameErr_d;

   // Synchronisers for the three asynchronous SPI lines. sdi has the same
   // depth as sck, so the bit taken at a detected sck rise is the one that
   // was on the wire at that rise. Only sck and load need the extra delay
   // flop, because only they are edge-detected.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sckSync_q  <= '0;
         sdiSync_q  <= '0;
         loadSync_q <= '0;
         sckDly_q   <= 1'b0;
         loadDly_q  <= 1'b0;
      end else begin
         sckSync_q  <= {sckSync_q[SYNC_STAGES-2:0],  sck};
         sdiSync_q  <= {sdiSync_q[SYNC_STAGES-2:0],  sdi};
         loadSync_q <= {loadSync_q[SYNC_STAGES-2:0], load};
         sckDly_q   <= sckSync_q[SYNC_STAGES-1];
         loadDly_q  <= loadSync_q[SYNC_STAGES-1];
      end
   end

   assign sckSync  = sckSync_q[SYNC_STAGES-1];
   assign sdiSync  = sdiSync_q[SYNC_STAGES-1];
   assign loadSync = loadSync_q[SYNC_STAGES-1];
   assign sckRise  = sckSync  & ~sckDly_q;
   assign loadRise = loadSync & ~loadDly_q;
   assign loadFall = ~loadSync & loadDly_q;

   // Frame FSM. A load rise in IDLE opens a frame. In SHIFT every sck rise
   // shifts one bit in and bumps a saturating counter. An sck rise in the
   // same cycle as the load fall is ignored, so a late edge cannot turn a
   // short frame into a valid one. COMMIT lasts one cycle. It either
   // publishes all three words at once or reports the frame as bad.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      count_d     = count_q;
      prd1_d      = prd1_q;
      prd2_d      = prd2_q;
      prd3_d      = prd3_q;
      voice_d     = voice_q;
      frameDone_d = 1'b0;
      frameErr_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (loadRise) begin
               shift_d = '0;
               count_d = '0;
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            if (loadFall) begin
               state_d = COMMIT;
            end else if (sckRise) begin
               shift_d = {shift_q[FRAME_W-2:0], sdiSync};
               if (count_q != COUNT_MAX) begin
                  count_d = count_q + 7'd1;
               end
            end
         end

         COMMIT: begin
            state_d = IDLE;
            if (count_q == FRAME_BITS) begin
               prd1_d      = shift_q[FRAME_W-1:2*WORD_W];
               prd2_d      = shift_q[2*WORD_W-1:WORD_W];
               prd3_d      = shift_q[WORD_W-1:0];
               voice_d     = {|shift_q[WORD_W-1:0],
                              |shift_q[2*WORD_W-1:WORD_W],
                              |shift_q[FRAME_W-1:2*WORD_W]};
               frameDone_d = 1'b1;
            end else begin
               frameErr_d  = 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers. Every output comes straight from a flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         count_q     <= '0;
         prd1_q      <= '0;
         prd2_q      <= '0;
         prd3_q      <= '0;
         voice_q     <= '0;
         frameDone_q <= 1'b0;
         frameErr_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         count_q     <= count_d;
         prd1_q      <= prd1_d;
         prd2_q      <= prd2_d;
         prd3_q      <= prd3_d;
         voice_q     <= voice_d;
         frameDone_q <= frameDone_d;
         frameErr_q  <= frameErr_d;
      end
   end

   assign prd1       = {1'b0, prd1_q};
   assign prd2       = {1'b0, prd2_q};
   assign prd3       = {1'b0, prd3_q};
   assign voice_on   = voice_q;
   assign frame_done = frameDone_q;
   assign frame_err  = frameErr_q;

endmodule

// File: doc/note_spi_rx.md
# note_spi_rx

Front-end SPI receiver for the waveform synthesiser. It takes three note periods from the PIC over a three-wire SPI link (sck, sdi, load) and presents them as stable 33-bit period words to the square/sawtooth/triangle/sine voice generators. Frames update all three periods together, so the generators never see a mix of old and new notes. Malformed frames are dropped and flagged.

## Interface
- SYNC_STAGES, 2: synchroniser depth for sck, sdi and load; legal values are 2 and 3.
- WORD_W, 32: bits transmitted per voice. The frame is 3×WORD_W = 96 bits.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sck  in  1  SPI clock from the PIC; asynchronous to clk; idles low.
- sdi  in  1  SPI data, MSB first; the PIC changes it on the sck falling edge.
- load  in  1  frame enable, active-high; asynchronous. High for the whole frame.
- prd1, prd2, prd3  out  33 each  committed periods in clk cycles; bit 32 is always 0.
- voice_on  out  3  bit i-1 is high when prd_i != 0.
- frame_done  out  1  one-cycle pulse when a valid frame is committed.
- frame_err  out  1  one-cycle pulse when a frame is discarded.

## Operation
- Synchronisation: each of sck, sdi and load passes through SYNC_STAGES flops, then one extra flop for edge detection. sdi uses the same depth as sck, so the data sampled is aligned with the detected sck edge.
- FSM IDLE:
  - Rising edge of synchronised load clears the 96-bit shift register and the 7-bit bit counter, then moves to SHIFT.
  - sck edges are ignored in IDLE.
- FSM SHIFT:
  - Each synchronised sck rising edge shifts synchronised sdi into the LSB and increments the counter.
  - The counter saturates at 127.
  - Falling edge of synchronised load moves to COMMIT.
  - An sck rising edge detected in the same cycle as the load falling edge is not counted.
- FSM COMMIT (one cycle), then IDLE:
  - If count == 96: prd1 = {1'b0, sr[95:64]}, prd2 = {1'b0, sr[63:32]}, prd3 = {1'b0, sr[31:0]}. voice_on updates in the same edge. frame_done pulses.
  - Otherwise: the outputs hold and frame_err pulses.
- Bit order: the first bit received is the prd1 MSB.
- A period of 0 means the note is off. prd_i is still driven as 0.
- A load rising edge while in COMMIT is not possible, because load must stay low for at least 3 clk cycles. Any load rising edge seen in IDLE starts a new frame.
- Reset, including mid-frame:
  - prd1/2/3 = 0, voice_on = 0, frame_done = 0, frame_err = 0.
  - FSM goes to IDLE; shift register, counter and all synchroniser flops go to 0.
  - If load is already high at reset release, the synchronised rise starts a frame partway through. That frame ends with frame_err, which is the required behaviour.

## Timing
- Outputs are registered with no combinational paths from input to output.
- sck high and sck low must each last at least SYNC_STAGES+1 clk periods. sdi must be stable for SYNC_STAGES+1 clk periods around the sck rising edge.
- load:
  - Must stay low for at least SYNC_STAGES+1 clk periods between frames.
  - Must rise at least SYNC_STAGES+1 clk periods before the first sck rise.
  - Must fall at least SYNC_STAGES+1 clk periods after the last sck fall.
- Commit latency: let E0 be the first clk edge that samples load low.
  - For SYNC_STAGES=2, the FSM enters COMMIT at E2.
  - prd/voice_on change, and frame_done or frame_err goes high, at E3.
  - The pulse is high for exactly one cycle.
  - In general the update edge is E(SYNC_STAGES+1).
- frame_done and frame_err are never high together. Neither fires without a preceding load rise seen in IDLE.

## Test plan
- Reset, then a 96-bit frame of 0x0000_BB80, 0x0000_9470, 0x0000_7A12 → prd1=0x0BB80, prd2=0x09470, prd3=0x07A12, voice_on=3'b111, a single frame_done pulse at E3.
- Frame of 0x0000_1000, 0, 0xFFFF_FFFF → prd3=0x0_FFFF_FFFF with bit32=0, voice_on=3'b101.
- Frame of 95 bits, and a separate frame of 97 bits → frame_err pulses, prd and voice_on keep their previous values, frame_done stays 0.
- 200 sck pulses in one frame → counter saturates, frame_err pulses once; the next good frame commits normally.
- sck toggling while load is low → no shift occurs, no pulse, outputs unchanged.
- rst_n asserted after 40 bits of a frame, released with load still high, then load falls → all outputs 0 during reset, then frame_err. The next full frame commits correctly.
